// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump
// Purpose  : Streams a contiguous, wrapping range of register-file words out
//            over a valid/ready interface. One register is read per LOAD
//            cycle and then offered in SEND, so at most one word leaves every
//            two cycles. With REG_DUMP_CHECKSUM_EN defined, the XOR of all
//            accepted words follows as one extra word.
// Macro    : REG_DUMP_CHECKSUM_EN  (optional checksum word, off by default)
// Ports    : i_clk, i_rst        clock, async active-high reset
//            i_start, i_abort    start request (IDLE only) / cancel
//            i_first_addr/i_last_addr   inclusive address range, wraps 31->0
//            o_rd_addr, i_rd_data       async register-file read port
//            o_data, o_valid, i_ready   output word handshake
//            o_busy, o_done, o_count    status: active, done pulse, words sent
// Revision : 1.0  initial release
// ============================================================================
module reg_dump #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [4:0]        i_first_addr,
   input  logic [4:0]        i_last_addr,
   output logic [4:0]        o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [5:0]        o_count
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_LOAD = 3'd1;
   localparam logic [2:0] c_SEND = 3'd2;
   localparam logic [2:0] c_CSUM = 3'd3;
   localparam logic [2:0] c_DONE = 3'd4;

   // Highest address; the next address after it is 0.
   localparam logic [4:0] c_LAST_IDX = 5'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
   localparam logic [2:0] c_AFTER_LAST = c_CSUM;
`else
   localparam logic [2:0] c_AFTER_LAST = c_DONE;
`endif

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic [4:0]        r_cur;
   logic [4:0]        r_last;
   logic [DATA_W-1:0] r_data;
   logic [5:0]        r_count;
   logic              w_at_last;
   logic [4:0]        w_cur_next;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;
`endif

   assign w_at_last  = (r_cur == r_last);
   assign w_cur_next = (r_cur == c_LAST_IDX) ? 5'd0 : r_cur + 5'd1;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Abort beats a simultaneous handshake.
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (i_start) begin
               w_next_state = c_LOAD;
            end
         end
         c_LOAD: begin
            w_next_state = i_abort ? c_IDLE : c_SEND;
         end
         c_SEND: begin
            if (i_abort) begin
               w_next_state = c_IDLE;
            end else if (i_ready) begin
               w_next_state = w_at_last ? c_AFTER_LAST : c_LOAD;
            end
         end
         c_CSUM: begin
            if (i_abort) begin
               w_next_state = c_IDLE;
            end else if (i_ready) begin
               w_next_state = c_DONE;
            end
         end
         c_DONE: begin
            w_next_state = c_IDLE;
         end
         default: begin
            w_next_state = c_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin
      o_valid = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (r_state)
         c_LOAD: begin
            o_busy = 1'b1;
         end
         c_SEND, c_CSUM: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
         end
         c_DONE: begin
            o_done = 1'b1;
         end
         default: begin
            o_valid = 1'b0;
         end
      endcase
   end

   // The read address simply follows the current pointer; it is only
   // meaningful to the register file during LOAD.
   assign o_rd_addr = r_cur;
   assign o_data    = r_data;
   assign o_count   = r_count;

   // ------------------------------------------------------------------
   // Datapath: address pointers, word register, counter, checksum
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cur   <= 5'd0;
         r_last  <= 5'd0;
         r_data  <= '0;
         r_count <= 6'd0;
`ifdef REG_DUMP_CHECKSUM_EN
         r_csum  <= '0;
`endif
      end else begin
         case (r_state)
            c_IDLE: begin
               if (i_start) begin
                  r_cur   <= i_first_addr;
                  r_last  <= i_last_addr;
                  r_count <= 6'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                  r_csum  <= '0;
`endif
               end
            end
            c_LOAD: begin
               // Per-word snapshot of the register file.
               if (!i_abort) begin
                  r_data <= i_rd_data;
               end
            end
            c_SEND: begin
               if (i_ready && !i_abort) begin
                  r_count <= r_count + 6'd1;
`ifdef REG_DUMP_CHECKSUM_EN
                  r_csum  <= r_csum ^ r_data;
`endif
                  if (!w_at_last) begin
                     r_cur <= w_cur_next;
                  end
`ifdef REG_DUMP_CHECKSUM_EN
                  else begin
                     // Present the final checksum (including this word)
                     // through the same output register in CSUM.
                     r_data <= r_csum ^ r_data;
                  end
`endif
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
